// File: rtl/viterbi_decoder_r34_pkg.sv
// Shared definitions for the rate-3/4 punctured K=3 code: state encoding,
// puncture phases with their lane masks, and the encoder's expected parity.
package viterbi_decoder_r34_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    localparam int unsigned N_STATES = 4;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;

    // Lane masks as {use_p1, use_p0}
    localparam logic [1:0] MASK_PH0 = 2'b11;
    localparam logic [1:0] MASK_PH1 = 2'b10;
    localparam logic [1:0] MASK_PH2 = 2'b01;

    function automatic logic [1:0] erase_mask(input logic [1:0] ph);
        case (ph)
            PH1:     return MASK_PH1;
            PH2:     return MASK_PH2;
            default: return MASK_PH0;
        endcase
    endfunction

    // State is {s1,s0}; s0 holds the most recent input bit.
    function automatic logic [1:0] exp_par(input logic [1:0] prev, input logic in_bit);
        return {in_bit ^ prev[0] ^ prev[1], in_bit ^ prev[1]};
    endfunction

endpackage

// File: rtl/viterbi_acs_r34.sv
// Add-compare-select for one next state: two predecessor metrics plus their
// branch metrics in, saturated survivor metric and predecessor choice out.
module viterbi_acs_r34 #(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    localparam logic [PM_W-1:0] PM_MAX = '1;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;

    // Ties keep the predecessor whose MSB is 0
    always_comb begin
        c0     = sat_add(pm0, bm0);
        c1     = sat_add(pm1, bm1);
        dec    = (c1 < c0);
        pm_new = dec ? c1 : c0;
    end

endmodule

// File: rtl/viterbi_decoder_r34.sv
// Hard-decision Viterbi decoder for the rate-3/4 punctured 4-state code,
// register-exchange survivors of depth TB_DEPTH.
module viterbi_decoder_r34
    import viterbi_decoder_r34_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 15,
    parameter int unsigned PM_W     = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            sync,
    input  logic            in_valid,
    input  logic [1:0]      din,
    output logic            dout,
    output logic            dout_valid,
    output logic [PM_W-1:0] best_metric
);

    localparam logic [PM_W-1:0] PM_MAX   = '1;
    localparam logic [5:0]      FILL_MAX = 6'(TB_DEPTH);

    logic [1:0]          phase;
    logic [1:0]          phase_nxt;
    logic [5:0]          fill;
    logic [5:0]          fill_nxt;
    logic [PM_W-1:0]     pm       [N_STATES];
    logic [PM_W-1:0]     pm_raw   [N_STATES];
    logic [PM_W-1:0]     pm_nrm   [N_STATES];
    logic [PM_W-1:0]     pm_min;
    logic [TB_DEPTH-1:0] surv     [N_STATES];
    logic [TB_DEPTH-1:0] surv_nxt [N_STATES];
    logic [N_STATES-1:0] dec;
    logic [1:0]          bm       [N_STATES][2];
    logic [1:0]          mask;
    logic [1:0]          diff;
    logic [1:0]          prev;
    logic [1:0]          best;

    // Branch metrics indexed [prev state][input bit]; erased lanes are masked out
    always_comb begin
        mask = erase_mask(phase);
        diff = '0;
        for (int unsigned p = 0; p < N_STATES; p++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                diff     = (din ^ exp_par(2'(p), 1'(b))) & mask;
                bm[p][b] = {1'b0, diff[1]} + {1'b0, diff[0]};
            end
        end
    end

    for (genvar n = 0; n < N_STATES; n++) begin : g_acs
        localparam int unsigned A = n / 2;
        localparam int unsigned B = n % 2;
        viterbi_acs_r34 #(.PM_W(PM_W)) u_acs (
            .pm0    (pm[A]),
            .pm1    (pm[A+2]),
            .bm0    (bm[A][B]),
            .bm1    (bm[A+2][B]),
            .pm_new (pm_raw[n]),
            .dec    (dec[n])
        );
    end

    // Winner of next state {a,b} is {dec,a}; the appended decision bit is b
    always_comb begin
        prev     = '0;
        surv_nxt = '{default: '0};
        for (int unsigned n = 0; n < N_STATES; n++) begin
            prev        = {dec[n], n[1]};
            surv_nxt[n] = {surv[prev][TB_DEPTH-2:0], n[0]};
        end
    end

    always_comb begin
        best   = S00;
        pm_min = pm_raw[0];
        for (int unsigned n = 1; n < N_STATES; n++) begin
            if (pm_raw[n] < pm_min) begin
                pm_min = pm_raw[n];
                best   = 2'(n);
            end
        end
        for (int unsigned n = 0; n < N_STATES; n++) begin
            pm_nrm[n] = (pm_raw[n] == PM_MAX) ? PM_MAX : pm_raw[n] - pm_min;
        end
    end

    always_comb begin
        phase_nxt = (phase == PH2) ? PH0 : phase + 2'd1;
        fill_nxt  = (fill == FILL_MAX) ? fill : fill + 6'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase       <= PH0;
            fill        <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            best_metric <= '0;
            for (int unsigned n = 0; n < N_STATES; n++) begin
                pm[n]   <= PM_MAX;
                surv[n] <= '0;
            end
            pm[S00] <= '0;
        end else if (sync) begin
            phase       <= PH0;
            fill        <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            best_metric <= '0;
            for (int unsigned n = 0; n < N_STATES; n++) begin
                pm[n]   <= PM_MAX;
                surv[n] <= '0;
            end
            pm[S00] <= '0;
        end else if (in_valid) begin
            phase       <= phase_nxt;
            fill        <= fill_nxt;
            best_metric <= pm_nrm[best];
            dout_valid  <= (fill_nxt == FILL_MAX);
            if (fill_nxt == FILL_MAX) begin
                dout <= surv_nxt[best][TB_DEPTH-1];
            end
            for (int unsigned n = 0; n < N_STATES; n++) begin
                pm[n]   <= pm_nrm[n];
                surv[n] <= surv_nxt[n];
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_r34.sv
// Bench for viterbi_decoder_r34: full-path Viterbi model, random streams with
// channel errors, literal all-zero/impulse cases, sync and async reset.
module tb_viterbi_decoder_r34;

    localparam int TBD   = 15;
    localparam int PMW   = 6;
    localparam int PMMAX = 63;
    localparam int MAXL  = 1024;

    logic           CLK      = 1'b0;
    logic           RST_N    = 1'b0;
    logic           sync     = 1'b0;
    logic           in_valid = 1'b0;
    logic [1:0]     din      = 2'b00;
    logic           dout;
    logic           dout_valid;
    logic [PMW-1:0] best_metric;

    viterbi_decoder_r34 #(.TB_DEPTH(TBD), .PM_W(PMW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .sync        (sync),
        .in_valid    (in_valid),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .best_metric (best_metric)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    int  m_pm [4];
    bit  m_path [4][MAXL];
    bit  np [4][MAXL];
    int  m_len, m_phase, m_fill;
    bit  exp_dout, exp_valid;
    int  exp_bm;

    bit       src   [400];
    bit       gap   [400];
    int       vhist [400];
    bit       got [$];
    int       valid_cnt = 0;
    bit       inject = 1'b0;
    bit       chk_en = 1'b0;
    int       rec_on = 0;
    logic [7:0] trA [$];
    logic [7:0] trB [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pm[0] = 0; m_pm[1] = PMMAX; m_pm[2] = PMMAX; m_pm[3] = PMMAX;
        m_len = 0; m_phase = 0; m_fill = 0;
        exp_dout = 1'b0; exp_valid = 1'b0; exp_bm = 0;
    endtask

    // Full-history Viterbi: every state keeps its entire decided path
    task automatic model_step(input bit [1:0] d);
        int npm [4];
        int win [4];
        int mn, best;
        bit use1, use0;
        use1 = (m_phase != 2);
        use0 = (m_phase != 1);
        for (int n = 0; n < 4; n++) begin
            int a, b;
            a = n / 2; b = n % 2;
            npm[n] = -1; win[n] = 0;
            for (int k = 0; k < 2; k++) begin
                int p, bmv, c;
                bit e1, e0;
                p  = 2 * k + a;
                e1 = ((b + p % 2 + p / 2) % 2) == 1;
                e0 = ((b + p / 2) % 2) == 1;
                bmv = ((use1 && (d[1] != e1)) ? 1 : 0) + ((use0 && (d[0] != e0)) ? 1 : 0);
                c = m_pm[p] + bmv;
                if (c > PMMAX) c = PMMAX;
                if (npm[n] < 0 || c < npm[n]) begin
                    npm[n] = c; win[n] = p;
                end
            end
        end
        mn = npm[0]; best = 0;
        for (int n = 1; n < 4; n++) if (npm[n] < mn) begin mn = npm[n]; best = n; end
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < m_len; i++) np[n][i] = m_path[win[n]][i];
            np[n][m_len] = (n % 2) == 1;
        end
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i <= m_len; i++) m_path[n][i] = np[n][i];
            m_pm[n] = (npm[n] == PMMAX) ? PMMAX : npm[n] - mn;
        end
        m_len++;
        m_phase = (m_phase + 1) % 3;
        if (m_fill < TBD) m_fill++;
        exp_bm = m_pm[best];
        exp_valid = (m_fill == TBD);
        if (exp_valid) exp_dout = m_path[best][m_len - TBD];
    endtask

    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            check("dout_valid", int'(dout_valid), int'(exp_valid));
            check("best_metric", int'(best_metric), exp_bm);
            check("dout", int'(dout), int'(exp_dout));
            if (dout_valid) begin
                got.push_back(dout);
                valid_cnt++;
            end
            if (rec_on == 1) trA.push_back({dout_valid, dout, best_metric});
            else if (rec_on == 2) trB.push_back({dout_valid, dout, best_metric});
        end
    end

    task automatic sym(input logic [1:0] d);
        @(negedge CLK);
        in_valid = 1'b1; sync = 1'b0; din = d;
        model_step(d);
        @(posedge CLK); #2;
    endtask

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0; sync = 1'b0; din = 2'($urandom_range(0, 3));
        exp_valid = 1'b0;
        @(posedge CLK); #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0; in_valid = 1'b0; sync = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        got.delete();
    endtask

    task automatic gen_src(input int n);
        for (int i = 0; i < n; i++) src[i] = ($urandom_range(0, 1) == 1);
    endtask

    // Encodes src plus TBD-1 zero tail bits and feeds the punctured symbols
    task automatic run_frame(input int n_data, input bit use_x, input int max_syms);
        bit s0, s1;
        int total;
        s0 = 1'b0; s1 = 1'b0;
        total = n_data + TBD - 1;
        for (int i = 0; i < total && i < max_syms; i++) begin
            bit b, p1, p0;
            logic era;
            logic [1:0] d;
            era = use_x ? 1'bx : 1'b0;
            b  = (i < n_data) ? src[i] : 1'b0;
            p1 = b ^ s0 ^ s1;
            p0 = b ^ s1;
            s1 = s0; s0 = b;
            if (inject && i < n_data && i % 20 == 10) begin
                if (i % 3 == 2) p0 = ~p0; else p1 = ~p1;
            end
            case (i % 3)
                0:       d = {p1, p0};
                1:       d = {p1, era};
                default: d = {era, p0};
            endcase
            if (gap[i]) idle();
            sym(d);
            vhist[i] = valid_cnt;
        end
    endtask

    task automatic check_decode(input string name, input int n);
        int nbad;
        nbad = 0;
        check({name, "_count"}, (got.size() >= n) ? 1 : 0, 1);
        for (int k = 0; k < n && k < got.size(); k++) if (got[k] != src[k]) nbad++;
        check({name, "_bits"}, nbad, 0);
    endtask

    initial begin
        int first, ones, nzbm, base, nbad;
        logic era;
        era = 1'bx;
        model_reset();
        for (int i = 0; i < 400; i++) gap[i] = ($urandom_range(0, 3) == 0);
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_dout_valid", int'(dout_valid), 0);
        check("reset_dout", int'(dout), 0);
        check("reset_best_metric", int'(best_metric), 0);
        RST_N = 1'b1;

        // All-zero data: 00, 0x, x0 repeating
        first = -1; ones = 0; nzbm = 0;
        for (int i = 0; i < 60; i++) begin
            case (i % 3)
                0:       sym(2'b00);
                1:       sym({1'b0, era});
                default: sym({era, 1'b0});
            endcase
            if (dout_valid && first < 0) first = i;
            if (dout) ones++;
            if (best_metric != 0) nzbm++;
        end
        check("allzero_first_valid_sym", first, TBD - 1);
        check("allzero_ones", ones, 0);
        check("allzero_best_metric", nzbm, 0);

        // Impulse: data 1 then zeros
        do_reset();
        nzbm = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)      sym(2'b11);
            else if (i == 1) sym({1'b1, era});
            else if (i == 2) sym({era, 1'b1});
            else begin
                case (i % 3)
                    0:       sym(2'b00);
                    1:       sym({1'b0, era});
                    default: sym({era, 1'b0});
                endcase
            end
            if (best_metric != 0) nzbm++;
        end
        check("impulse_count", got.size(), 30 - TBD + 1);
        check("impulse_first_bit", (got.size() > 0) ? int'(got[0]) : -1, 1);
        ones = 0;
        for (int k = 1; k < got.size(); k++) if (got[k]) ones++;
        check("impulse_later_ones", ones, 0);
        check("impulse_best_metric", nzbm, 0);

        // Random 300 bits, one channel error every 20 symbols
        do_reset();
        gen_src(300);
        inject = 1'b1;
        run_frame(300, 1'b1, 999);
        check_decode("random300", 300);

        // Erased lanes as x versus 0: identical traces
        gen_src(90);
        do_reset();
        rec_on = 1; run_frame(90, 1'b1, 999); rec_on = 0;
        do_reset();
        rec_on = 2; run_frame(90, 1'b0, 999); rec_on = 0;
        inject = 1'b0;
        check("erase_trace_len", trB.size(), trA.size());
        nbad = 0;
        for (int k = 0; k < trA.size() && k < trB.size(); k++) if (trA[k] !== trB[k]) nbad++;
        check("erase_trace_diffs", nbad, 0);

        // sync with in_valid high at symbol 40
        gen_src(60);
        do_reset();
        run_frame(60, 1'b0, 40);
        @(negedge CLK);
        in_valid = 1'b1; sync = 1'b1; din = 2'($urandom_range(0, 3));
        model_reset();
        @(posedge CLK); #2;
        check("sync_valid_low", int'(dout_valid), 0);
        gen_src(60);
        got.delete();
        base = valid_cnt;
        run_frame(60, 1'b0, 999);
        check("sync_no_valid_14", vhist[TBD - 2] - base, 0);
        check("sync_valid_at_15", vhist[TBD - 1] - base, 1);
        check_decode("sync_frame", 60);

        // Async reset mid-cycle after symbol 25
        gen_src(60);
        do_reset();
        run_frame(60, 1'b0, 25);
        check("pre_reset_valid", int'(dout_valid), 1);
        #1;
        RST_N = 1'b0; in_valid = 1'b0;
        model_reset();
        #1;
        check("async_reset_valid", int'(dout_valid), 0);
        check("async_reset_best_metric", int'(best_metric), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        got.delete();
        run_frame(60, 1'b0, 999);
        check_decode("after_reset", 60);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
